// File: rtl/perf_event_monitor.sv
// Performance event monitor. It counts cycles, retired instructions and NUM_CH event strobes,
// freezes all counters on halt, and returns counter values through a registered read port.
module perf_event_monitor #(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 32,
   parameter int SATURATE = 0,
   parameter int SEL_W    = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_clr,
   input  logic              i_halt,
   input  logic              i_retire,
   input  logic [NUM_CH-1:0] i_ev,
   input  logic              i_rd_req,
   input  logic [SEL_W-1:0]  i_rd_sel,
   output logic              o_rd_valid,
   output logic [CNT_W-1:0]  o_rd_data,
   output logic              o_rd_ovf,
   output logic              o_rd_err,
   output logic              o_frozen
);

   // state    | meaning
   // S_IDLE   | not counting, waiting for en
   // S_RUN    | every cycle counted, retire/ev strobes counted
   // S_FROZEN | counters held after halt; only clr leaves
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN} state_t;

   localparam int NUM_CNT = NUM_CH + 2;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_frozen;
   logic [CNT_W-1:0]   r_cnt     [NUM_CNT];
   logic [CNT_W-1:0]   w_cnt_nxt [NUM_CNT];
   logic [NUM_CNT-1:0] r_ovf;
   logic [NUM_CNT-1:0] w_ovf_nxt;
   logic [NUM_CNT-1:0] w_inc;

   logic               r_rd_valid;
   logic [CNT_W-1:0]   r_rd_data;
   logic               r_rd_ovf;
   logic               r_rd_err;
   logic [CNT_W-1:0]   w_rd_data;
   logic               w_rd_ovf;
   logic               w_rd_err;

   // Index 0 counts cycles, index 1 counts retired instructions, index 2+k counts channel k.
   assign w_inc = {i_ev, i_retire, 1'b1};

   always_comb begin
      w_state_nxt = r_state;
      if (i_clr) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:   if (i_en) w_state_nxt = S_RUN;
            S_RUN: begin
               if (i_halt)     w_state_nxt = S_FROZEN;
               else if (!i_en) w_state_nxt = S_IDLE;
            end
            S_FROZEN: w_state_nxt = S_FROZEN;
            default:  w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CNT; i++) begin
         w_cnt_nxt[i] = r_cnt[i];
         w_ovf_nxt[i] = r_ovf[i];
         if ((r_state == S_RUN) && w_inc[i]) begin
            if (&r_cnt[i]) begin
               w_ovf_nxt[i] = 1'b1;
               w_cnt_nxt[i] = (SATURATE != 0) ? r_cnt[i] : '0;
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_frozen <= 1'b0;
         r_ovf    <= '0;
         for (int i = 0; i < NUM_CNT; i++) r_cnt[i] <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_frozen <= (w_state_nxt == S_FROZEN);
         if (i_clr) begin
            r_ovf <= '0;
            for (int i = 0; i < NUM_CNT; i++) r_cnt[i] <= '0;
         end else begin
            r_ovf <= w_ovf_nxt;
            for (int i = 0; i < NUM_CNT; i++) r_cnt[i] <= w_cnt_nxt[i];
         end
      end
   end

   // The read mux looks at the pre-edge counter values, so the request cycle's own events are excluded.
   assign w_rd_err = (i_rd_sel > SEL_W'(NUM_CNT - 1));

   always_comb begin
      w_rd_data = '0;
      w_rd_ovf  = 1'b0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (i_rd_sel == SEL_W'(i)) begin
            w_rd_data = r_cnt[i];
            w_rd_ovf  = r_ovf[i];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_rd_ovf   <= 1'b0;
         r_rd_err   <= 1'b0;
      end else begin
         r_rd_valid <= i_rd_req;
         if (i_rd_req) begin
            r_rd_data <= w_rd_data;
            r_rd_ovf  <= w_rd_ovf;
            r_rd_err  <= w_rd_err;
         end
      end
   end

   assign o_rd_valid = r_rd_valid;
   assign o_rd_data  = r_rd_data;
   assign o_rd_ovf   = r_rd_ovf;
   assign o_rd_err   = r_rd_err;
   assign o_frozen   = r_frozen;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed bench for perf_event_monitor: the default 32-bit instance plus two 4-bit instances
// (wrapping and saturating) that share the same stimulus.
module tb_perf_event_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, clr = 1'b0, halt = 1'b0, retire = 1'b0, rd_req = 1'b0;
   logic [3:0] ev = 4'b0000;
   logic [2:0] rd_sel = 3'd0;

   logic        rd_valid, rd_ovf, rd_err, frozen;
   logic [31:0] rd_data;
   logic        w_valid, w_ovf, w_err, w_frozen;
   logic [3:0]  w_data;
   logic        s_valid, s_ovf, s_err, s_frozen;
   logic [3:0]  s_data;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   perf_event_monitor #(.NUM_CH(4), .CNT_W(32), .SATURATE(0), .SEL_W(3)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_halt(halt), .i_retire(retire),
      .i_ev(ev), .i_rd_req(rd_req), .i_rd_sel(rd_sel), .o_rd_valid(rd_valid),
      .o_rd_data(rd_data), .o_rd_ovf(rd_ovf), .o_rd_err(rd_err), .o_frozen(frozen));

   perf_event_monitor #(.NUM_CH(4), .CNT_W(4), .SATURATE(0), .SEL_W(3)) u_wrap (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_halt(halt), .i_retire(retire),
      .i_ev(ev), .i_rd_req(rd_req), .i_rd_sel(rd_sel), .o_rd_valid(w_valid),
      .o_rd_data(w_data), .o_rd_ovf(w_ovf), .o_rd_err(w_err), .o_frozen(w_frozen));

   perf_event_monitor #(.NUM_CH(4), .CNT_W(4), .SATURATE(1), .SEL_W(3)) u_sat (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_halt(halt), .i_retire(retire),
      .i_ev(ev), .i_rd_req(rd_req), .i_rd_sel(rd_sel), .o_rd_valid(s_valid),
      .o_rd_data(s_data), .o_rd_ovf(s_ovf), .o_rd_err(s_err), .o_frozen(s_frozen));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [2:0] sel, input logic [31:0] exp_data, input logic exp_ovf,
                     input logic exp_err, input string tag);
      rd_req = 1'b1;
      rd_sel = sel;
      tick();
      rd_req = 1'b0;
      check({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check({tag, "_data"},  rd_data, exp_data);
      check({tag, "_ovf"},   32'(rd_ovf), 32'(exp_ovf));
      check({tag, "_err"},   32'(rd_err), 32'(exp_err));
   endtask

   initial begin
      // Reset
      tick();
      tick();
      check("rst_valid",  32'(rd_valid), 32'd0);
      check("rst_data",   rd_data, 32'd0);
      check("rst_frozen", 32'(frozen), 32'd0);
      check("rst_err",    32'(rd_err), 32'd0);
      rst = 1'b0;
      tick();

      // 1: ten counted cycles, retire on six, ev=0101 each cycle
      en = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         en     = (i < 9);
         ev     = 4'b0101;
         retire = (i < 6);
         tick();
      end
      ev = 4'b0000;
      retire = 1'b0;
      rd(3'd0, 32'd10, 1'b0, 1'b0, "t1_cyc");
      rd(3'd1, 32'd6,  1'b0, 1'b0, "t1_ret");
      rd(3'd2, 32'd10, 1'b0, 1'b0, "t1_ch0");
      rd(3'd4, 32'd10, 1'b0, 1'b0, "t1_ch2");
      rd(3'd3, 32'd0,  1'b0, 1'b0, "t1_ch1");
      tick();
      check("t1_valid_idle", 32'(rd_valid), 32'd0);

      // 2: halt in the fifth RUN cycle, then counters frozen
      clr = 1'b1;
      tick();
      clr = 1'b0;
      en = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         ev     = 4'b0001;
         retire = (i == 1) || (i == 4);
         halt   = (i == 4);
         tick();
         if (i == 3) check("t2_not_frozen", 32'(frozen), 32'd0);
      end
      check("t2_frozen", 32'(frozen), 32'd1);
      for (int i = 0; i < 20; i++) begin
         en     = (i % 2 == 0);
         ev     = 4'b1111;
         retire = 1'b1;
         halt   = (i % 3 == 0);
         tick();
      end
      en = 1'b0; ev = 4'b0000; retire = 1'b0; halt = 1'b0;
      rd(3'd0, 32'd5, 1'b0, 1'b0, "t2_cyc");
      rd(3'd1, 32'd2, 1'b0, 1'b0, "t2_ret");
      rd(3'd2, 32'd5, 1'b0, 1'b0, "t2_ch0");
      rd(3'd5, 32'd0, 1'b0, 1'b0, "t2_ch3");
      check("t2_still_frozen", 32'(frozen), 32'd1);

      // 4: clr and halt together while in RUN, with a read of the pre-clear value
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("t4_unfrozen", 32'(frozen), 32'd0);
      en = 1'b1;
      tick();
      tick();
      clr = 1'b1; halt = 1'b1; rd_req = 1'b1; rd_sel = 3'd0;
      tick();
      clr = 1'b0; halt = 1'b0; rd_req = 1'b0; en = 1'b0;
      check("t4_preclr_valid", 32'(rd_valid), 32'd1);
      check("t4_preclr_data",  rd_data, 32'd1);
      check("t4_frozen",       32'(frozen), 32'd0);
      rd(3'd0, 32'd0, 1'b0, 1'b0, "t4_cyc0");
      rd(3'd1, 32'd0, 1'b0, 1'b0, "t4_ret0");
      rd(3'd2, 32'd0, 1'b0, 1'b0, "t4_ch00");
      check("t4_idle_frozen", 32'(frozen), 32'd0);
      en = 1'b1;
      tick();
      tick();
      tick();
      en = 1'b0;
      tick();
      rd(3'd0, 32'd3, 1'b0, 1'b0, "t4_cyc3");

      // 5: back-to-back reads of channel 1 while it counts, then out-of-range selects
      clr = 1'b1;
      tick();
      clr = 1'b0;
      en = 1'b1;
      tick();
      ev = 4'b0010;
      tick();
      rd_req = 1'b1;
      rd_sel = 3'd3;
      for (int j = 0; j < 3; j++) begin
         tick();
         check("t5_b2b_valid", 32'(rd_valid), 32'd1);
         check("t5_b2b_data",  rd_data, 32'(1 + j));
      end
      rd_req = 1'b0;
      tick();
      check("t5_valid_drop", 32'(rd_valid), 32'd0);
      check("t5_data_hold",  rd_data, 32'd3);
      rd(3'd7, 32'd0, 1'b0, 1'b1, "t5_sel7");
      rd(3'd6, 32'd0, 1'b0, 1'b1, "t5_sel6");
      rd(3'd5, 32'd0, 1'b0, 1'b0, "t5_sel5");

      // 6: asynchronous reset mid-cycle during RUN with a read outstanding
      rd_req = 1'b1;
      rd_sel = 3'd0;
      tick();
      check("t6_pre_valid", 32'(rd_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_valid", 32'(rd_valid), 32'd0);
      check("t6_async_data",  rd_data, 32'd0);
      check("t6_async_err",   32'(rd_err), 32'd0);
      check("t6_async_ovf",   32'(rd_ovf), 32'd0);
      tick();
      check("t6_no_valid", 32'(rd_valid), 32'd0);
      rd_req = 1'b0;
      en = 1'b0;
      ev = 4'b0000;
      rst = 1'b0;
      tick();
      rd(3'd0, 32'd0, 1'b0, 1'b0, "t6_cyc0");
      rd(3'd3, 32'd0, 1'b0, 1'b0, "t6_ch10");

      // 3: 4-bit counters, 17 strobes on ev[0]
      en = 1'b1;
      tick();
      rd_sel = 3'd2;
      for (int i = 0; i < 17; i++) begin
         en     = (i < 16);
         ev     = 4'b0001;
         rd_req = (i == 15);
         tick();
         if (i == 15) begin
            check("t3_wrap15_data", 32'(w_data), 32'd15);
            check("t3_wrap15_ovf",  32'(w_ovf),  32'd0);
            check("t3_sat15_data",  32'(s_data), 32'd15);
            check("t3_sat15_ovf",   32'(s_ovf),  32'd0);
         end
      end
      rd_req = 1'b0;
      ev = 4'b0000;
      rd(3'd2, 32'd17, 1'b0, 1'b0, "t3_main");
      check("t3_wrap_valid", 32'(w_valid), 32'd1);
      check("t3_wrap_data",  32'(w_data),  32'd1);
      check("t3_wrap_ovf",   32'(w_ovf),   32'd1);
      check("t3_sat_valid",  32'(s_valid), 32'd1);
      check("t3_sat_data",   32'(s_data),  32'd15);
      check("t3_sat_ovf",    32'(s_ovf),   32'd1);
      check("t3_sat_err",    32'(s_err),   32'd0);
      check("t3_frozen",     32'(w_frozen | s_frozen), 32'd0);

      // Overflow flag is sticky until clr
      rd(3'd0, 32'd17, 1'b0, 1'b0, "t3_cyc");
      rd_sel = 3'd2;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      check("t3_clr_wrap_ovf", 32'(w_ovf), 32'd0);
      check("t3_clr_sat_data", 32'(s_data), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, checks=%0d", n_checks);
      $fatal(1);
   end

endmodule

// File: doc/perf_event_monitor.md
Name: perf_event_monitor

Overview:
- Synthesizable, parametrised successor to the bench-only instruction/cache-event counting in the processor top-level bench.
- Lives beside the pipeline and caches. Counts cycles, retired instructions and NUM_CH event strobes (ICacheReq, ICacheHit, DCacheReq, DCacheHit, ...).
- Freezes all counters on Halt. Exposes counters through a registered request/valid read port, so bench and on-chip debug logic read identical values.

Parameters:
- NUM_CH, 4, number of event channels.
- CNT_W, 32, width of every counter.
- SATURATE, 0, 1 = counters stick at all-ones on overflow; 0 = counters wrap to 0.
- SEL_W, 3, width of rd_sel. Must satisfy 2^SEL_W >= NUM_CH+2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  count enable; level-sensitive.
- clr  in  1  synchronous clear of all counters and overflow flags.
- halt  in  1  Halt strobe from the pipeline (instruction in MEM/WB).
- retire  in  1  one instruction retired this cycle (Halt, RegWrite or MemWrite).
- ev  in  NUM_CH  per-channel event strobes; one increment per asserted bit per cycle.
- rd_req  in  1  read request; sampled each clock.
- rd_sel  in  SEL_W  counter select: 0 = cycles, 1 = instret, 2+k = channel k.
- rd_valid  out  1  read data valid, one cycle after rd_req.
- rd_data  out  CNT_W  selected counter value.
- rd_ovf  out  1  sticky overflow flag of the selected counter.
- rd_err  out  1  rd_sel out of range (> NUM_CH+1).
- frozen  out  1  monitor is in state FROZEN.

Behaviour:
- Reset (async, rst=1): state IDLE; all counters and overflow flags 0; rd_valid, rd_data, rd_ovf, rd_err and frozen all 0.
- State machine, transitions on the clk rising edge:
  - Priority order: clr > halt > en.
  - IDLE: en=1 -> RUN. The cycle in which en is first seen high is not counted.
  - RUN: counting active. clr -> IDLE. halt=1 -> FROZEN. en=0 -> IDLE, counters hold.
  - FROZEN: counters hold regardless of en, ev, retire and halt. Only clr -> IDLE.
- Counting happens only in RUN, in every cycle where the state is RUN at the start of the cycle:
  - cycle counter +1.
  - instret +1 if retire.
  - channel k +1 if ev[k].
- The halt cycle itself is counted: cycle, retire and ev increments from that cycle are included, then the monitor freezes.
- halt and clr in the same cycle: clr wins. Counters are cleared and the state goes to IDLE, not FROZEN.
- Overflow, when a counter at all-ones is incremented:
  - The counter's ovf flag is set and stays set until clr or rst.
  - SATURATE=1: value stays at all-ones.
  - SATURATE=0: value wraps to 0.
- clr zeroes all counters and ovf flags at the next edge.
- Read port:
  - rd_req=1 at edge N -> rd_valid=1 during cycle N+1.
  - rd_data/rd_ovf show the selected register value before the edge-N update, so the request cycle's own events are excluded.
  - Back-to-back requests are allowed, one result per cycle. rd_valid=0 whenever no request was sampled.
  - rd_data holds its last value when rd_valid=0.
  - rd_sel out of range: rd_data=0, rd_ovf=0, rd_err=1, rd_valid=1.
  - rd_req in the same cycle as clr returns the pre-clear value.
  - Reads are honoured in every state, including IDLE and FROZEN.
- frozen=1 exactly while the state is FROZEN.
- Reset asserted mid-operation (including mid-read): everything returns to reset values immediately. A pending rd_valid is dropped.

Test Plan:
1. rst, en=1, then 10 RUN cycles with retire=1 on 6 of them and ev=4'b0101 every cycle; read sel 0,1,2,4 -> 10, 6, 10, 10. Read sel 3 -> 0.
2. halt=1 in RUN cycle 5 with retire=1 -> frozen=1 next cycle. cycles=5 and instret includes the halt. 20 further ev/retire cycles -> counters unchanged.
3. CNT_W=4: 17 ev[0] strobes. SATURATE=0 -> rd_data=1, rd_ovf=1. SATURATE=1 -> rd_data=15, rd_ovf=1.
4. clr and halt in the same cycle -> state IDLE, frozen=0, all reads 0. Then en=1 and 3 cycles -> cycles=3.
5. rd_req held high for 3 cycles with ev[1] every cycle, sel=3 -> rd_valid high 3 cycles with values k, k+1, k+2. sel=7 (NUM_CH=4) -> rd_err=1, rd_data=0.
6. rst pulsed asynchronously between edges during RUN with rd_req=1 -> all outputs 0 immediately. No rd_valid on the following edge.
